// File: rtl/leaf_rx_demux.sv
// BFT leaf receive demux: 16-deep packet FIFO whose head is steered to one of four ports.
// Optional feature macro: LEAF_RX_DROP_CNT_EN adds the drop_cnt port (invalid-port discard counter).
module leaf_rx_demux (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ap_start,
  input  logic [48:0] din_leaf_bft2interface,
  output logic        almost_full,
  output logic        overflow,
  output logic [31:0] dout_data,
  output logic [3:0]  dout_valid,
  input  logic [3:0]  dout_ready
`ifdef LEAF_RX_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  logic [35:0] r_mem [16];
  logic [3:0]  r_wptr, r_rptr;
  logic [4:0]  r_count;
  logic        r_ovf, r_af;
  logic [31:0] r_last;

  logic [35:0] w_head;
  logic [3:0]  w_port;
  logic        w_nonempty, w_show, w_drop, w_pop;
  logic        w_in_vld, w_push, w_lost;
  logic [4:0]  w_count_nxt;
  logic        w_unused_fields;

  assign w_unused_fields = ^{din_leaf_bft2interface[47:43], din_leaf_bft2interface[38:32]};

  always_comb begin
    w_head      = r_mem[r_rptr];
    w_port      = w_head[35:32];
    w_nonempty  = (r_count != 5'd0);
    w_show      = w_nonempty && (w_port[3:2] == 2'b00);
    // Heads aimed at a nonexistent port are discarded without ever being presented.
    w_drop      = w_nonempty && (w_port[3:2] != 2'b00);
    w_pop       = w_drop || (w_show && dout_ready[w_port[1:0]]);
    w_in_vld    = din_leaf_bft2interface[48] && ap_start;
    w_push      = w_in_vld && ((r_count != 5'd16) || w_pop);
    w_lost      = w_in_vld && (r_count == 5'd16) && !w_pop;
    w_count_nxt = r_count + 5'(w_push) - 5'(w_pop);
  end

  always_comb begin
    dout_valid = 4'b0000;
    dout_data  = r_last;
    if (w_show) begin
      dout_valid = 4'b0001 << w_port[1:0];
      dout_data  = w_head[31:0];
    end
  end

  assign almost_full = r_af;
  assign overflow    = r_ovf;

  // Storage is not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (reset_n && w_push)
      r_mem[r_wptr] <= {din_leaf_bft2interface[42:39], din_leaf_bft2interface[31:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= 4'd0;
      r_rptr  <= 4'd0;
      r_count <= 5'd0;
      r_ovf   <= 1'b0;
      r_af    <= 1'b0;
      r_last  <= 32'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 4'd1;
      if (w_pop)  r_rptr <= r_rptr + 4'd1;
      r_count <= w_count_nxt;
      if (w_lost) r_ovf <= 1'b1;
      r_af <= (w_count_nxt >= 5'd12);
      if (w_show) r_last <= w_head[31:0];
    end
  end

`ifdef LEAF_RX_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_drop_cnt <= 16'd0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_leaf_rx_demux.sv
// Directed bench for leaf_rx_demux: vector table plus fill/overflow and full-with-pop sequences.
module tb_leaf_rx_demux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ap_start;
  logic [48:0] din;
  logic        almost_full, overflow;
  logic [31:0] dout_data;
  logic [3:0]  dout_valid, dout_ready;
`ifdef LEAF_RX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  leaf_rx_demux dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .ap_start               (ap_start),
    .din_leaf_bft2interface (din),
    .almost_full            (almost_full),
    .overflow               (overflow),
    .dout_data              (dout_data),
    .dout_valid             (dout_valid),
    .dout_ready             (dout_ready)
`ifdef LEAF_RX_DROP_CNT_EN
    ,
    .drop_cnt               (drop_cnt)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        ap;
    logic [48:0] din;
    logic [3:0]  rdy;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic        eaf;
    logic        eovf;
  } vec_t;

  vec_t tv[$];

  function automatic logic [48:0] pkt(input logic [3:0] p, input logic [31:0] d);
    return {1'b1, 5'd0, p, 7'd0, d};
  endfunction

  function automatic vec_t mk(input logic r, input logic a, input logic [48:0] d, input logic [3:0] rd,
                              input logic [3:0] ev, input logic [31:0] ed, input logic eaf, input logic eovf);
    vec_t v;
    v.rst_n = r; v.ap = a; v.din = d; v.rdy = rd;
    v.ev = ev; v.ed = ed; v.eaf = eaf; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; ap_start = 1'b0; din = '0; dout_ready = 4'b0000;

    // Reset
    tv.push_back(mk(0, 0, '0, 4'b0000, 4'b0000, 32'h0, 0, 0));
    // Single packet to port 2
    tv.push_back(mk(1, 1, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}, 4'b0100, 4'b0100, 32'hDEADBEEF, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b0100, 4'b0000, 32'hDEADBEEF, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b0000, 4'b0000, 32'hDEADBEEF, 0, 0));
    // Invalid port 9 sandwiched between two port-1 packets; other ready bits ignored
    tv.push_back(mk(1, 1, pkt(4'd1, 32'h11111111), 4'b0000, 4'b0010, 32'h11111111, 0, 0));
    tv.push_back(mk(1, 1, pkt(4'd9, 32'h99999999), 4'b1101, 4'b0010, 32'h11111111, 0, 0));
    tv.push_back(mk(1, 1, pkt(4'd1, 32'h22222222), 4'b0010, 4'b0000, 32'h11111111, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b0000, 4'b0010, 32'h22222222, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b0010, 4'b0000, 32'h22222222, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b0000, 4'b0000, 32'h22222222, 0, 0));
    // Gated: ap_start low, then valid bit low
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(1, 0, pkt(4'd0, 32'hA0 + 32'(i)), 4'b1111, 4'b0000, 32'h22222222, 0, 0));
    tv.push_back(mk(1, 1, {1'b0, 5'd0, 4'd0, 7'd0, 32'hBAD}, 4'b1111, 4'b0000, 32'h22222222, 0, 0));
    // Three accepted, then reset with a packet on din
    tv.push_back(mk(1, 1, pkt(4'd0, 32'hC1), 4'b0000, 4'b0001, 32'hC1, 0, 0));
    tv.push_back(mk(1, 1, pkt(4'd0, 32'hC2), 4'b0000, 4'b0001, 32'hC1, 0, 0));
    tv.push_back(mk(1, 1, pkt(4'd0, 32'hC3), 4'b0000, 4'b0001, 32'hC1, 0, 0));
    tv.push_back(mk(0, 1, pkt(4'd0, 32'hC4), 4'b0000, 4'b0000, 32'h0, 0, 0));
    // First cycle after reset accepts
    tv.push_back(mk(1, 1, pkt(4'd3, 32'hD5), 4'b0000, 4'b1000, 32'hD5, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b1000, 4'b0000, 32'hD5, 0, 0));
    tv.push_back(mk(1, 1, '0, 4'b0000, 4'b0000, 32'hD5, 0, 0));

    foreach (tv[i]) begin
      reset_n = tv[i].rst_n; ap_start = tv[i].ap; din = tv[i].din; dout_ready = tv[i].rdy;
      tick();
      chk($sformatf("vec%0d.valid", i), 32'(dout_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d.data", i), dout_data, tv[i].ed);
      chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(tv[i].eaf));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tv[i].eovf));
`ifdef LEAF_RX_DROP_CNT_EN
      if (i == 9)  chk("drop_cnt.after_invalid", 32'(drop_cnt), 32'd1);
      if (i == 19) chk("drop_cnt.after_reset", 32'(drop_cnt), 32'd0);
`endif
    end

    // Fill with 17 port-0 packets, no consumer
    reset_n = 1'b1; ap_start = 1'b1; dout_ready = 4'b0000;
    for (int i = 1; i <= 17; i++) begin
      din = pkt(4'd0, 32'h10000000 + 32'(i));
      tick();
      chk($sformatf("fill%0d.almost_full", i), 32'(almost_full), 32'(i >= 12));
      chk($sformatf("fill%0d.overflow", i), 32'(overflow), 32'(i == 17));
      chk($sformatf("fill%0d.data", i), dout_data, 32'h10000001);
    end
    // Drain with ap_start low
    din = '0; ap_start = 1'b0; dout_ready = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d.valid", k), 32'(dout_valid), 32'h1);
      chk($sformatf("drain%0d.data", k), dout_data, 32'h10000000 + 32'(k));
      tick();
    end
    chk("drain.empty", 32'(dout_valid), 32'h0);
    chk("drain.almost_full", 32'(almost_full), 32'h0);
    chk("drain.overflow_sticky", 32'(overflow), 32'h1);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst.overflow", 32'(overflow), 32'h0);

    // Full plus simultaneous pop
    ap_start = 1'b1; dout_ready = 4'b0000;
    for (int i = 1; i <= 16; i++) begin
      din = pkt(4'd0, 32'h20000000 + 32'(i));
      tick();
    end
    chk("full.almost_full", 32'(almost_full), 32'h1);
    chk("full.overflow", 32'(overflow), 32'h0);
    chk("full.head", dout_data, 32'h20000001);
    din = pkt(4'd0, 32'h20000011); dout_ready = 4'b0001;
    tick();
    chk("fullpop.overflow", 32'(overflow), 32'h0);
    chk("fullpop.almost_full", 32'(almost_full), 32'h1);
    din = '0; ap_start = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      chk($sformatf("fpdrain%0d.valid", k), 32'(dout_valid), 32'h1);
      chk($sformatf("fpdrain%0d.data", k), dout_data, 32'h20000000 + 32'(k));
      tick();
    end
    chk("fpdrain.empty", 32'(dout_valid), 32'h0);
    chk("fpdrain.overflow", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/leaf_rx_demux.md
LEAF_RX_DEMUX -- requirements
Module: leaf_rx_demux

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL provide port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL provide port ap_start, input, 1 bit: packet acceptance enable.
REQ-004 SHALL provide port din_leaf_bft2interface, input, 49 bits: BFT leaf packet, with fields as follows.
- [48]: valid
- [47:43]: destination leaf
- [42:39]: destination port
- [38:32]: reserved
- [31:0]: payload
REQ-005 SHALL provide port almost_full, output, 1 bit: flow-control hint to the BFT.
REQ-006 SHALL provide port overflow, output, 1 bit: sticky flag set when a packet is lost to a full FIFO.
REQ-007 SHALL provide port dout_data, output, 32 bits: payload of the packet at the FIFO head, shared by all ports.
REQ-008 SHALL provide port dout_valid, output, 4 bits: one-hot; bit p asserts when the head packet targets port p.
REQ-009 SHALL provide port dout_ready, input, 4 bits: per-port consumer ready.
REQ-010 SHALL provide port drop_cnt, output, 16 bits, present only under LEAF_RX_DROP_CNT_EN.

Function
REQ-011 SHALL buffer accepted packets in a 16-entry FIFO storing bits [42:39] and [31:0], with a 5-bit occupancy count (0..16).
REQ-012 SHALL accept (write) when din[48]=1, ap_start=1, and (count<16 or a pop occurs in the same cycle).
REQ-013 SHALL ignore din when din[48]=0 or ap_start=0, with no flag or count change.
REQ-014 SHALL discard a packet and set overflow=1 when din[48]=1, ap_start=1, count=16 and there is no same-cycle pop; overflow holds until reset.
REQ-015 SHALL make a packet written at edge k visible at the head (dout_valid/dout_data) in the cycle after edge k; minimum latency is 1 cycle.
REQ-016 SHALL, when count>0 and the head port value is p<4, drive dout_valid to one-hot bit p and dout_data to the head payload; otherwise dout_valid=0 and dout_data holds its last value.
REQ-017 SHALL pop the head when dout_valid[p]=1 and dout_ready[p]=1; dout_ready bits for other ports have no effect.
REQ-018 SHALL discard a head packet with port>=4 by popping it in the cycle it reaches the head, without asserting any dout_valid bit.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and keep packet order strictly FIFO.
REQ-020 SHALL wrap read and write pointers modulo 16.
REQ-021 SHALL register almost_full=1 when the next count is >=12 and almost_full=0 when it is <12, taking effect one cycle after the crossing edge.
REQ-022 SHALL keep draining the FIFO while ap_start=0.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, clear the following and discard any packet present on din in that cycle:
- count and both pointers
- overflow=0, almost_full=0
- dout_valid=0, dout_data=0
- drop_cnt=0
REQ-024 SHALL drop all buffered packets on a reset asserted mid-stream; FIFO storage contents need not be cleared.
REQ-025 SHALL accept a packet presented in the first cycle after reset_n returns high.

Configuration
REQ-026 SHALL, with macro LEAF_RX_DROP_CNT_EN defined, provide drop_cnt, which increments by 1 per packet discarded under REQ-018 and saturates at 16'hFFFF.
REQ-027 SHALL, without LEAF_RX_DROP_CNT_EN, omit port drop_cnt and its logic; all other behaviour is identical.

Verification
REQ-028 Bench SHALL cover single packet: ap_start=1, din={1,5'd3,4'd2,7'd0,32'hDEADBEEF}, dout_ready=4'b0100 -> dout_valid=4'b0100 and dout_data=32'hDEADBEEF one cycle later; popped the following edge; count returns to 0.
REQ-029 Bench SHALL cover fill/overflow: 17 back-to-back port-0 packets with dout_ready=0 -> almost_full=1 from the cycle after the 12th write; the 17th packet is lost; overflow=1; the 16 packets then drain in order.
REQ-030 SHALL cover full with simultaneous pop: count=16, dout_ready=4'b0001, valid packet on din -> packet accepted, count stays 16, overflow stays 0.
REQ-031 Bench SHALL cover invalid port: head packet with port 4'd9 between two port-1 packets -> it is never presented on dout_valid; drop_cnt=1 with LEAF_RX_DROP_CNT_EN defined; both port-1 packets are delivered in order.
REQ-032 Bench SHALL cover gating and reset: ap_start=0 with 5 valid packets -> none accepted; then 3 packets accepted followed by reset_n=0 for 1 cycle -> count=0, dout_valid=0, overflow=0, almost_full=0.
